// File: rtl/fifo_write.sv
// -----------------------------------------------------------------------------
// fifo_write
//   Serialises a frame of up to 12 bytes from a 96-bit word into a byte-wide
//   FIFO write port, honouring downstream backpressure and an abort input.
//
//   Byte k of the frame is data[8k +: 8]. With the ascending [0:95] range this
//   is the most significant byte first, so byte 0 sits in data[0:7].
//
//   Optional feature (compile-time macro):
//     FIFO_WRITE_CSUM_EN  - append one checksum byte (XOR of every data byte
//                           written in the frame) after the data bytes.
//
//   Ports
//     clk        in   1   single clock, rising edge
//     rst        in   1   asynchronous reset, active low
//     err        in   1   abort request; in any non-idle state forces IDLE
//     BYTE_NUM   in   4   bytes per frame (0 = none, 13..15 clamp to 12)
//     data       in  96   frame word, byte 0 = data[0:7]
//     fifo_full  in   1   downstream FIFO full (backpressure)
//     fifo_txd   out  8   registered byte presented to the FIFO
//     fifo_txen  out  1   FIFO write enable (only combinational output)
//     state_fw   out  4   current state code, zero-extended
//     fs         in   1   frame start request (level)
//     fd         out  1   frame done (level, high while in LAST)
// -----------------------------------------------------------------------------
module fifo_write (
  input  logic        clk,
  input  logic        rst,
  input  logic        err,
  input  logic [3:0]  BYTE_NUM,
  input  logic [0:95] data,
  input  logic        fifo_full,
  output logic [7:0]  fifo_txd,
  output logic        fifo_txen,
  output logic [3:0]  state_fw,
  input  logic        fs,
  output logic        fd
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WORK = 3'd2,
    HOLD = 3'd3,
`ifdef FIFO_WRITE_CSUM_EN
    CSUM = 3'd4,
`endif
    LAST = 3'd5
  } state_t;

  state_t      r_state;
  logic [0:95] r_shift;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic [7:0]  r_txd;
  logic        r_fd;
`ifdef FIFO_WRITE_CSUM_EN
  logic [7:0]  r_csum;
`endif

  state_t      w_next;
  logic        w_accept;
  logic        w_last_byte;
  logic [3:0]  w_len_in;

  // Oversized lengths are clamped at load time so the counter never passes 11.
  assign w_len_in    = (BYTE_NUM > 4'd12) ? 4'd12 : BYTE_NUM;
  assign w_last_byte = (r_cnt == (r_len - 4'd1));

  // Next-state and write-accept decode. err overrides everything outside IDLE,
  // and also blocks a start request arriving in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (fs && !err) w_next = LOAD;
      end
      LOAD: begin
        if (err) begin
          w_next = IDLE;
        end else if (w_len_in == 4'd0) begin
`ifdef FIFO_WRITE_CSUM_EN
          w_next = CSUM;
`else
          w_next = LAST;
`endif
        end else begin
          w_next = WORK;
        end
      end
      WORK: begin
        if (err) begin
          w_next = IDLE;
        end else if (fifo_full) begin
          w_next = HOLD;
        end else begin
          w_accept = 1'b1;
          if (w_last_byte) begin
`ifdef FIFO_WRITE_CSUM_EN
            w_next = CSUM;
`else
            w_next = LAST;
`endif
          end
        end
      end
      HOLD: begin
        if (err)             w_next = IDLE;
        else if (!fifo_full) w_next = WORK;
      end
`ifdef FIFO_WRITE_CSUM_EN
      // The checksum byte stalls in place while the FIFO is full.
      CSUM: begin
        if (err) begin
          w_next = IDLE;
        end else if (!fifo_full) begin
          w_accept = 1'b1;
          w_next   = LAST;
        end
      end
`endif
      LAST: begin
        if (err || !fs) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // r_txd always holds the byte at the current counter position (or the
  // checksum once in CSUM), so the accepted byte is r_txd itself and the next
  // one is already waiting in r_shift[8:15].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_txd   <= '0;
      r_fd    <= 1'b0;
`ifdef FIFO_WRITE_CSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_fd    <= (w_next == LAST);
      case (r_state)
        LOAD: begin
          r_shift <= data;
          r_len   <= w_len_in;
          r_cnt   <= '0;
          r_txd   <= (w_len_in == 4'd0) ? 8'h00 : data[0:7];
`ifdef FIFO_WRITE_CSUM_EN
          r_csum  <= '0;
`endif
        end
        WORK: begin
          if (w_accept) begin
`ifdef FIFO_WRITE_CSUM_EN
            r_csum <= r_csum ^ r_txd;
`endif
            if (w_last_byte) begin
`ifdef FIFO_WRITE_CSUM_EN
              r_txd <= r_csum ^ r_txd;
`endif
            end else begin
              r_cnt   <= r_cnt + 4'd1;
              r_shift <= r_shift << 8;
              r_txd   <= r_shift[8:15];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_txen = w_accept;
  assign fifo_txd  = r_txd;
  assign fd        = r_fd;
  assign state_fw  = {1'b0, r_state};

endmodule

// File: tb/tb_fifo_write.sv
// -----------------------------------------------------------------------------
// tb_fifo_write
//   Frame stimulus pushes the bytes a frame should produce into exp_q; an
//   independent monitor pops one entry for every FIFO write it sees.
// -----------------------------------------------------------------------------
module tb_fifo_write;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err = 1'b0;
  logic        fs  = 1'b0;
  logic        fifo_full = 1'b0;
  logic [3:0]  BYTE_NUM = '0;
  logic [0:95] data = '0;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic [3:0]  state_fw;
  logic        fd;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  logic [7:0]  exp_q[$];

  fifo_write dut (
    .clk       (clk),
    .rst       (rst),
    .err       (err),
    .BYTE_NUM  (BYTE_NUM),
    .data      (data),
    .fifo_full (fifo_full),
    .fifo_txd  (fifo_txd),
    .fifo_txen (fifo_txen),
    .state_fw  (state_fw),
    .fs        (fs),
    .fd        (fd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a frame puts min(BYTE_NUM,12) bytes in order, then (with the
  // checksum option) their XOR. keep truncates the list for aborted frames.
  task automatic push_frame(input logic [0:95] d, input logic [3:0] bn, input int keep);
    int         n;
    logic [7:0] b;
    logic [7:0] x;
    n = (bn > 4'd12) ? 12 : int'(bn);
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = d[8*k +: 8];
      x = x ^ b;
      if (k < keep) exp_q.push_back(b);
    end
`ifdef FIFO_WRITE_CSUM_EN
    if (keep > n) exp_q.push_back(x);
`else
    if (x == 8'h00) b = 8'h00;
`endif
  endtask

  function automatic int exp_edges(input logic [3:0] bn);
    int n;
    n = (bn > 4'd12) ? 12 : int'(bn);
`ifdef FIFO_WRITE_CSUM_EN
    return n + 3;
`else
    return n + 2;
`endif
  endfunction

  // Monitor: every write must be expected, in order, and never during full/err.
  always @(negedge clk) begin
    if (rst && fifo_txen) begin
      check("txen_while_full", 32'(fifo_full), 32'd0);
      check("txen_during_err", 32'(err), 32'd0);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("fifo_txd", 32'(fifo_txd), 32'(exp_q.pop_front()));
      wr_count++;
    end
  end

  // Waits for fd with a cycle bound. Caller has just driven fs=1 after an edge.
  // Scrambles data/BYTE_NUM once the frame has been latched.
  task automatic wait_done(input bit rand_full, input int stall_after, input int lat);
    int edges;
    int stall_cnt;
    int wr0;
    bit pend;
    bit got;
    edges = 0; stall_cnt = 0; wr0 = wr_count; pend = (stall_after >= 0); got = 1'b0;
    while (!got && edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 2) begin
        data     = {$urandom(), $urandom(), $urandom()};
        BYTE_NUM = 4'($urandom_range(0, 15));
      end
      if (rand_full) begin
        fifo_full = ($urandom_range(0, 2) == 0);
      end else if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) fifo_full = 1'b0;
      end else if (pend && (wr_count - wr0) >= stall_after) begin
        fifo_full = 1'b1;
        stall_cnt = 3;
        pend      = 1'b0;
      end
      @(negedge clk);
      if (fd) got = 1'b1;
    end
    check("frame_done", 32'(got), 32'd1);
    check("all_bytes_written", 32'(exp_q.size()), 32'd0);
    if (lat > 0) check("done_latency", 32'(edges), 32'(lat));
    exp_q.delete();
    @(posedge clk); #1 fs = 1'b0; fifo_full = 1'b0;
    @(negedge clk);
    check("fd_held_until_fs_low", 32'(fd), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_frame", 32'(state_fw), 32'd0);
    check("fd_low_in_idle", 32'(fd), 32'd0);
  endtask

  task automatic run_frame(input logic [0:95] d, input logic [3:0] bn, input bit rand_full,
                           input int stall_after, input bit chk_lat);
    push_frame(d, bn, 99);
    @(posedge clk); #1;
    data = d; BYTE_NUM = bn; fs = 1'b1; fifo_full = 1'b0;
    wait_done(rand_full, stall_after, chk_lat ? exp_edges(bn) : 0);
  endtask

  task automatic err_frame(input logic [0:95] d, input logic [3:0] bn, input int after);
    int wr0;
    int edges;
    push_frame(d, bn, after);
    @(posedge clk); #1;
    data = d; BYTE_NUM = bn; fs = 1'b1; fifo_full = 1'b0;
    wr0 = wr_count; edges = 0;
    while ((wr_count - wr0) < after && edges < 100) begin
      @(posedge clk);
      edges++;
    end
    check("err_point_reached", 32'(wr_count - wr0), 32'(after));
    #1 err = 1'b1; fs = 1'b0;
    @(negedge clk);
    check("txen_low_on_err", 32'(fifo_txen), 32'd0);
    @(posedge clk); #1 err = 1'b0;
    @(negedge clk);
    check("idle_after_err", 32'(state_fw), 32'd0);
    check("no_fd_on_err", 32'(fd), 32'd0);
    repeat (5) @(negedge clk);
    check("no_writes_after_err", 32'(wr_count - wr0), 32'(after));
    check("err_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_mid_frame(input logic [0:95] d);
    int wr0;
    int edges;
    push_frame(d, 4'd8, 99);
    @(posedge clk); #1;
    data = d; BYTE_NUM = 4'd8; fs = 1'b1; fifo_full = 1'b0;
    wr0 = wr_count; edges = 0;
    while ((wr_count - wr0) < 3 && edges < 100) begin
      @(posedge clk);
      edges++;
    end
    #2 check("txen_before_reset", 32'(fifo_txen), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_txen", 32'(fifo_txen), 32'd0);
    check("rst_async_txd", 32'(fifo_txd), 32'd0);
    check("rst_async_fd", 32'(fd), 32'd0);
    check("rst_async_state", 32'(state_fw), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 check("rst_hold_state", 32'(state_fw), 32'd0);
    // Frame restarts from byte 0 with fs still held.
    push_frame(d, 4'd8, 99);
    rst = 1'b1;
    wait_done(1'b0, -1, exp_edges(4'd8));
  endtask

  initial begin
    logic [0:95] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_txen", 32'(fifo_txen), 32'd0);
    check("reset_txd", 32'(fifo_txd), 32'd0);
    check("reset_fd", 32'(fd), 32'd0);
    check("reset_state", 32'(state_fw), 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    check("state_after_release", 32'(state_fw), 32'd0);

    // 12-byte frame, no backpressure, consecutive writes 01..0C.
    run_frame(96'h0102030405060708090A0B0C, 4'd12, 1'b0, -1, 1'b1);

    // Stall for three cycles right after the second byte.
    d = {32'hAABBCCDD, 64'h0};
    run_frame(d, 4'd4, 1'b0, 2, 1'b0);

    // Length 0 and clamped length 15.
    run_frame({$urandom(), $urandom(), $urandom()}, 4'd0, 1'b0, -1, 1'b1);
    run_frame({$urandom(), $urandom(), $urandom()}, 4'd15, 1'b0, -1, 1'b1);

    // Abort after two bytes of a six-byte frame, then a clean frame.
    err_frame({$urandom(), $urandom(), $urandom()}, 4'd6, 2);
    run_frame({$urandom(), $urandom(), $urandom()}, 4'd6, 1'b0, -1, 1'b1);

    // err and fs together in IDLE: err wins.
    @(posedge clk); #1 fs = 1'b1; err = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("err_beats_fs", 32'(state_fw), 32'd0);
    @(posedge clk); #1 fs = 1'b0; err = 1'b0;
    @(negedge clk);
    run_frame({$urandom(), $urandom(), $urandom()}, 4'd5, 1'b0, -1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    reset_mid_frame({$urandom(), $urandom(), $urandom()});

    // Random frames under random backpressure.
    repeat (25) begin
      run_frame({$urandom(), $urandom(), $urandom()}, 4'($urandom_range(0, 15)), 1'b1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_write.md
FIFO_WRITE -- requirements
Module: fifo_write

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port err, input, 1: abort request, sampled on clk.
REQ-004 SHALL have port BYTE_NUM, input, 4: bytes per frame, 1..12; 0 and 13..15 per REQ-017.
REQ-005 SHALL have port data, input, [0:95]: frame word; byte k = data[8k +: 8], byte 0 sent first.
REQ-006 SHALL have port fifo_full, input, 1: downstream FIFO full, backpressure.
REQ-007 SHALL have port fifo_txd, output, 8: byte written to the FIFO.
REQ-008 SHALL have port fifo_txen, output, 1: FIFO write enable, one byte per high cycle.
REQ-009 SHALL have port state_fw, output, 4: current state code, zero-extended.
REQ-010 SHALL have port fs, input, 1: frame start request, level.
REQ-011 SHALL have port fd, output, 1: frame done, level.

Function
REQ-012 SHALL implement states IDLE=0, LOAD=1, WORK=2, HOLD=3, CSUM=4, LAST=5; any other code SHALL go to IDLE next cycle.
REQ-013 IDLE: fs=1 -> LOAD; fs=0 -> stay.
REQ-014 LOAD, one cycle: latch data into a 96-bit shift register, latch BYTE_NUM into a length register, clear byte counter and checksum, go to WORK; fifo_txen=0.
REQ-015 WORK: fifo_txen = !fifo_full (combinational); fifo_txd = byte[counter] of the latched word. When a byte is accepted (fifo_txen=1), the counter SHALL increment and the checksum SHALL XOR in the byte. fifo_full=1 SHALL move to HOLD with no write.
REQ-016 HOLD: fifo_txen=0 and fifo_txd held; fifo_full=0 -> WORK. No byte is lost or repeated across any number of stall cycles.
REQ-017 Length: 0 SHALL write no data bytes (LOAD -> CSUM, or LOAD -> LAST without the macro); values 13..15 SHALL be clamped to 12.
REQ-018 After the accepted byte with counter = length-1, the next state SHALL be CSUM (macro defined) or LAST; the counter SHALL never exceed 11 or wrap.
REQ-019 LAST: fd=1 and fifo_txen=0; fs=0 -> IDLE, otherwise stay. fd SHALL be 0 in all other states.
REQ-020 data and BYTE_NUM changes after LOAD SHALL NOT affect the frame in progress.
REQ-021 err=1 in any state except IDLE SHALL force IDLE next cycle with fifo_txen=0 that cycle. A partial frame is not rolled back, and fd is not asserted.
REQ-022 If err=1 and fs=1 in the same cycle, err SHALL win; the next frame starts only from IDLE with err=0.
REQ-023 fifo_txd SHALL be registered (driven from flops); fifo_txen is the only combinational output.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, counter 0, checksum 0, shift register 0 and length 0.
REQ-025 During and after reset: fifo_txen=0, fifo_txd=8'h00, fd=0, state_fw=4'h0.
REQ-026 Reset mid-frame SHALL drop the frame; no write SHALL occur in the cycle rst deasserts.

Configuration
REQ-027 Macro FIFO_WRITE_CSUM_EN defined: CSUM state present. In CSUM, fifo_txd = XOR of all data bytes written in the frame (8'h00 if length 0). fifo_txen = !fifo_full, with the WORK/HOLD-style stall. The state goes to LAST when the byte is accepted.
REQ-028 Macro undefined: CSUM state and checksum register absent; WORK goes to LAST directly, and frames are exactly length bytes.

Verification
REQ-029 BYTE_NUM=12, data=96'h0102..0C, fifo_full=0, fs pulse held -> 12 consecutive fifo_txen cycles, fifo_txd 01..0C, then fd=1 until fs=0. With the macro, a 13th byte 0x0C precedes fd.
REQ-030 BYTE_NUM=4, data top bytes AA BB CC DD, fifo_full=1 for 3 cycles after byte BB -> sequence AA BB CC DD, with no txen during full and no duplicate. With the macro, checksum 0x00 follows.
REQ-031 BYTE_NUM=0 -> zero data writes and fd asserted. With the macro, exactly one write of 8'h00.
REQ-032 BYTE_NUM=15 -> exactly 12 data bytes written.
REQ-033 err=1 after the 2nd byte of a 6-byte frame -> state IDLE next cycle, no further writes, fd stays 0; a new fs frame then completes normally.
REQ-034 rst=0 asserted mid-WORK -> outputs zero immediately (asynchronous); after release with fs=1, the frame restarts from byte 0.
